// File: rtl/hilo_muldiv_unit.sv
// Iterative signed multiply/divide unit owning the HI/LO pair.
// Shift-add multiply and restoring divide on magnitudes, sign-corrected in a final FIX cycle.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       HiLo,
  output logic [WIDTH-1:0] hilo_data,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // Multiply: {partial product hi, multiplier/low}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_mult_q, is_mult_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    abs_a    = op_a[WIDTH-1] ? -op_a : op_a;
    abs_b    = op_b[WIDTH-1] ? -op_b : op_b;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Trial subtract of the divisor from {remainder, next dividend bit}; MSB set means borrow.
    div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
    prod     = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quot     = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_mult_d  = is_mult_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_mult || start_div) begin
          state_d    = StRun;
          cnt_d      = '0;
          is_mult_d  = start_mult;
          neg_a_d    = op_a[WIDTH-1];
          neg_b_d    = op_b[WIDTH-1];
          div_zero_d = !start_mult && (op_b == '0);
          opnd_d     = start_mult ? abs_a : abs_b;
          acc_d      = {{WIDTH{1'b0}}, (start_mult ? abs_b : abs_a)};
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (is_mult_q) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH+1]) begin
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (is_mult_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          hi_d = rem;
          lo_d = div_zero_q ? '1 : quot;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_mult_q  <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_mult_q  <= is_mult_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    busy  = (state_q != StIdle);
    stall = busy && ((HiLo != 2'b00) || start_mult || start_div);
    done  = done_q;
    unique case (HiLo)
      2'b10:   hilo_data = hi_q;
      2'b01:   hilo_data = lo_q;
      default: hilo_data = '0;
    endcase
  end

endmodule
